// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared constants, types and seven-segment encoding for mmss_timer.
// Revision : 1.0
// ============================================================================
package timer_pkg;

  // Time held as four BCD digits, most significant minutes digit first.
  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } mmss_t;

  localparam mmss_t MMSS_ONE = '{m1: 4'd0, m0: 4'd0, s1: 4'd0, s0: 4'd1};

  localparam logic       SEL_SEC     = 1'b0;
  localparam logic       SEL_MIN     = 1'b1;
  localparam logic       DP_ON       = 1'b0;
  localparam logic       DP_OFF      = 1'b1;
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [3:0] AN_BLANK    = 4'b1111;
  localparam logic [1:0] SCAN_DP_IDX = 2'd2;

  function automatic int unsigned rate_div(input int unsigned clk_hz,
                                           input int unsigned rate_hz);
    int unsigned d;
    d = clk_hz / rate_hz;
    return (d == 0) ? 1 : d;
  endfunction

  // Active-low segments, bit order g..a; non-decimal codes go dark.
  function automatic logic [6:0] seg7_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_gen.sv
`default_nettype none
// ============================================================================
// Module   : strobe_gen
// Purpose  : Free-running prescaler emitting a one-cycle strobe every DIV
//            enabled clocks.
// Revision : 1.0
// ============================================================================
module strobe_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear restarts the full period, so it also swallows a coincident strobe.
  assign strobe = en & ~clr & (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/mmss_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmss_timer
// Purpose  : MM:SS up/down timer with adjust mode, driving a multiplexed
//            four-digit active-low seven-segment display.
// Revision : 1.0
// ============================================================================
module mmss_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned ADJ_HZ   = 2,
  parameter int unsigned BLINK_HZ = 2,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned MAX_MIN  = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       adjust,
  input  logic       sel,
  input  logic       dir,
  input  logic       clr,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       expired,
  output logic       at_zero
);

  localparam int unsigned TICK_DIV  = rate_div(CLK_HZ, TICK_HZ);
  localparam int unsigned ADJ_DIV   = rate_div(CLK_HZ, ADJ_HZ);
  localparam int unsigned BLINK_DIV = rate_div(CLK_HZ, BLINK_HZ);
  localparam int unsigned SCAN_DIV  = rate_div(CLK_HZ, SCAN_HZ);

  localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

  logic tick_stb;
  logic adj_stb;
  logic blink_stb;
  logic scan_stb;

  mmss_t      time_q,  time_d;
  logic       exp_q,   exp_d;
  logic [1:0] scan_q,  scan_d;
  logic       blink_q, blink_d;
  logic [3:0] an_q,    an_d;
  logic [7:0] seg_q,   seg_d;
  logic [3:0] digit;

  strobe_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (run & ~adjust),
    .clr    (clr),
    .strobe (tick_stb)
  );

  strobe_gen #(.DIV(ADJ_DIV)) u_adj (
    .clk    (clk),
    .reset  (reset),
    .en     (adjust),
    .clr    (clr),
    .strobe (adj_stb)
  );

  strobe_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .clr    (1'b0),
    .strobe (blink_stb)
  );

  strobe_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .clr    (1'b0),
    .strobe (scan_stb)
  );

  // Seconds field only: 59 -> 00 without touching minutes.
  function automatic mmss_t sec_inc(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.s0 == 4'd9) begin
      r.s0 = 4'd0;
      r.s1 = (t.s1 == 4'd5) ? 4'd0 : t.s1 + 4'd1;
    end else begin
      r.s0 = t.s0 + 4'd1;
    end
    return r;
  endfunction

  function automatic mmss_t min_inc(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.m1 == MAX_M1 && t.m0 == MAX_M0) begin
      r.m1 = 4'd0;
      r.m0 = 4'd0;
    end else if (t.m0 == 4'd9) begin
      r.m0 = 4'd0;
      r.m1 = t.m1 + 4'd1;
    end else begin
      r.m0 = t.m0 + 4'd1;
    end
    return r;
  endfunction

  function automatic mmss_t count_up(input mmss_t t);
    mmss_t r;
    if (t.s1 == 4'd5 && t.s0 == 4'd9) begin
      r    = min_inc(t);
      r.s1 = 4'd0;
      r.s0 = 4'd0;
    end else begin
      r = sec_inc(t);
    end
    return r;
  endfunction

  // Down-count saturates at 00:00 rather than wrapping.
  function automatic mmss_t count_down(input mmss_t t);
    mmss_t r;
    r = t;
    if (t == '0) begin
      r = t;
    end else if (t.s1 == 4'd0 && t.s0 == 4'd0) begin
      r.s1 = 4'd5;
      r.s0 = 4'd9;
      if (t.m0 == 4'd0) begin
        r.m0 = 4'd9;
        r.m1 = t.m1 - 4'd1;
      end else begin
        r.m0 = t.m0 - 4'd1;
      end
    end else if (t.s0 == 4'd0) begin
      r.s0 = 4'd9;
      r.s1 = t.s1 - 4'd1;
    end else begin
      r.s0 = t.s0 - 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    time_d = time_q;
    exp_d  = 1'b0;
    if (clr) begin
      time_d = '0;
    end else if (adj_stb) begin
      time_d = (sel == SEL_SEC) ? sec_inc(time_q) : min_inc(time_q);
    end else if (tick_stb) begin
      if (dir) begin
        time_d = count_down(time_q);
        exp_d  = (time_q == MMSS_ONE);
      end else begin
        time_d = count_up(time_q);
      end
    end
  end

  always_comb begin
    scan_d  = scan_stb  ? scan_q + 2'd1 : scan_q;
    blink_d = blink_stb ? ~blink_q      : blink_q;

    case (scan_q)
      2'd0:    digit = time_q.s0;
      2'd1:    digit = time_q.s1;
      2'd2:    digit = time_q.m0;
      default: digit = time_q.m1;
    endcase

    // Upper scan half carries the minutes, lower half the seconds.
    an_d = ~(4'b0001 << scan_q);
    if (adjust && blink_q && ((sel == SEL_MIN) == scan_q[1])) begin
      an_d = AN_BLANK;
    end

    seg_d = {((scan_q == SCAN_DP_IDX) ? DP_ON : DP_OFF), seg7_encode(digit)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q  <= '0;
      exp_q   <= 1'b0;
      scan_q  <= 2'd0;
      blink_q <= 1'b0;
      an_q    <= AN_BLANK;
      seg_q   <= 8'hFF;
    end else begin
      time_q  <= time_d;
      exp_q   <= exp_d;
      scan_q  <= scan_d;
      blink_q <= blink_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign expired = exp_q;
  assign at_zero = (time_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_mmss_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmss_timer
// Purpose  : Randomised scoreboard bench for mmss_timer against a
//            seconds-count reference model.
// Revision : 1.0
// ============================================================================
module tb_mmss_timer;

  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int ADJ_HZ   = 50;
  localparam int BLINK_HZ = 25;
  localparam int SCAN_HZ  = 500;
  localparam int MAX_MIN  = 99;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int ADJ_DIV  = CLK_HZ / ADJ_HZ;
  localparam int WRAP_S   = (MAX_MIN + 1) * 60;
  localparam int RST_STATE = 32'h0000_3FFD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0, adjust = 1'b0, sel = 1'b0, dir = 1'b0, clr = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       expired, at_zero;

  mmss_timer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ADJ_HZ(ADJ_HZ),
    .BLINK_HZ(BLINK_HZ), .SCAN_HZ(SCAN_HZ), .MAX_MIN(MAX_MIN)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .adjust(adjust), .sel(sel),
    .dir(dir), .clr(clr), .seg(seg), .an(an), .expired(expired),
    .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    kind;
    int    val;
    string name;
  } item_t;

  item_t sbq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    pulses = 0;
  bit    mon_busy = 1'b0;
  int    t_ref = 0;
  int    exp_ref = 0;

  always @(negedge clk) if (expired === 1'b1) pulses++;

  task automatic cmp(input string nm, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endtask

  function automatic int dec7(input logic [6:0] s);
    case (s)
      7'h40: return 0;  7'h79: return 1;  7'h24: return 2;  7'h30: return 3;
      7'h19: return 4;  7'h12: return 5;  7'h02: return 6;  7'h78: return 7;
      7'h00: return 8;  7'h10: return 9;
      default: return 15;
    endcase
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int mmss(input int t);
    return (t / 60) * 100 + (t % 60);
  endfunction

  // ---------------- monitor side ----------------
  task automatic chk_frame(input int expv, input string nm);
    int         d[4];
    logic [3:0] seen;
    int         dp_bad;
    int         k;
    seen   = '0;
    dp_bad = 0;
    for (int i = 0; i < 4; i++) d[i] = 15;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 40 && seen != 4'hF; c++) begin
      k = slot_of(an);
      if (k >= 0) begin
        d[k]    = dec7(seg[6:0]);
        seen[k] = 1'b1;
        if (seg[7] !== (k != 2)) dp_bad++;
      end
      @(negedge clk);
    end
    cmp(nm, d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0], expv);
    cmp({nm, "_dp"}, dp_bad, 0);
  endtask

  // Over one full blink period the selected field is dark for half its slots.
  task automatic chk_blink(input int sel_v, input string nm);
    int c_blank, c_sec, c_min;
    c_blank = 0; c_sec = 0; c_min = 0;
    for (int c = 0; c < 80; c++) begin
      if (an == 4'b1111) c_blank++;
      if (an == 4'b1110) c_sec++;
      if (an == 4'b1011) c_min++;
      @(negedge clk);
    end
    cmp({nm, "_blank"}, c_blank, 20);
    cmp({nm, "_an1110"}, c_sec, (sel_v == 0) ? 10 : 20);
    cmp({nm, "_an1011"}, c_min, (sel_v == 0) ? 20 : 10);
  endtask

  task automatic chk_scan(input string nm);
    logic [3:0] prev;
    int changes, bad;
    changes = 0; bad = 0;
    prev = an;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (an != prev) begin
        changes++;
        if (an != {prev[2:0], prev[3]}) bad++;
      end
      prev = an;
    end
    cmp({nm, "_steps"}, changes, 8);
    cmp({nm, "_order"}, bad, 0);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        mon_busy = 1'b1;
        it = sbq.pop_front();
        case (it.kind)
          0: chk_frame(it.val, it.name);
          1: chk_blink(it.val, it.name);
          2: cmp(it.name, pulses, it.val);
          3: cmp(it.name, int'(at_zero), it.val);
          4: cmp(it.name, int'({an, seg, expired, at_zero}), it.val);
          default: chk_scan(it.name);
        endcase
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus side ----------------
  task automatic push(input int kind, input int val, input string nm);
    item_t it;
    it.kind = kind;
    it.val  = val;
    it.name = nm;
    sbq.push_back(it);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !mon_busy) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL monitor_timeout: got %0d pending, expected 0", sbq.size());
    sbq.delete();
  endtask

  task automatic check_all(input string nm);
    push(0, mmss(t_ref), nm);
    push(3, (t_ref == 0) ? 1 : 0, {nm, "_atzero"});
    push(2, exp_ref, {nm, "_expired"});
    wait_idle();
  endtask

  task automatic do_ticks(input int k, input logic d);
    dir = d;
    run = 1'b1;
    step(k * TICK_DIV);
    run = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (d == 1'b0) begin
        t_ref = (t_ref + 1) % WRAP_S;
      end else if (t_ref > 0) begin
        if (t_ref == 1) exp_ref++;
        t_ref--;
      end
    end
  endtask

  // run/dir are scrambled here to show they are ignored while adjusting.
  task automatic do_adj(input int k, input logic s);
    sel    = s;
    run    = 1'($urandom);
    dir    = 1'($urandom);
    adjust = 1'b1;
    step(k * ADJ_DIV);
    adjust = 1'b0;
    run    = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (s == 1'b0) t_ref = (t_ref / 60) * 60 + ((t_ref % 60) + 1) % 60;
      else           t_ref = (((t_ref / 60) + 1) % (MAX_MIN + 1)) * 60 + t_ref % 60;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    t_ref = 0;
  endtask

  task automatic do_blink(input logic s);
    sel    = s;
    adjust = 1'b1;
    step(5);
    push(1, int'(s), s ? "blink_min" : "blink_sec");
    step(5 * ADJ_DIV - 5);
    adjust = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (s == 1'b0) t_ref = (t_ref / 60) * 60 + ((t_ref % 60) + 1) % 60;
      else           t_ref = (((t_ref / 60) + 1) % (MAX_MIN + 1)) * 60 + t_ref % 60;
    end
    wait_idle();
  endtask

  initial begin : stim
    int op, k;
    #1 reset = 1'b1;
    step(2);
    push(4, RST_STATE, "reset_state");
    wait_idle();
    reset = 1'b0;
    check_all("after_reset");

    do_ticks(60, 1'b0);
    check_all("up_60_ticks");
    do_clr();
    do_adj(99, 1'b1);
    do_adj(59, 1'b0);
    check_all("preload_9959");
    do_ticks(1, 1'b0);
    check_all("wrap_to_0000");

    do_clr();
    do_adj(58, 1'b0);
    check_all("adj_0058");
    do_adj(3, 1'b0);
    check_all("adj_sec_wrap_0001");
    do_blink(1'b0);
    do_blink(1'b1);
    check_all("after_blink");

    do_clr();
    do_adj(2, 1'b0);
    check_all("load_0002");
    do_ticks(1, 1'b1);
    check_all("down_0001");
    do_ticks(1, 1'b1);
    check_all("down_expire");
    do_ticks(5, 1'b1);
    check_all("down_hold");

    do_clr();
    do_adj(12, 1'b1);
    do_adj(34, 1'b0);
    check_all("load_1234");
    dir = 1'b0;
    run = 1'b1;
    step(TICK_DIV - 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    t_ref = 0;
    push(3, 1, "clr_beats_tick");
    step(TICK_DIV - 1);
    run = 1'b0;
    check_all("clr_no_early_tick");
    run = 1'b1;
    step(1);
    run = 1'b0;
    t_ref = 1;
    check_all("clr_next_tick");

    do_clr();
    do_adj(7, 1'b1);
    do_adj(15, 1'b0);
    check_all("load_0715");
    dir = 1'b0;
    run = 1'b1;
    step(4);
    @(posedge clk);
    #2 reset = 1'b1;
    push(4, RST_STATE, "reset_midcount");
    run = 1'b0;
    wait_idle();
    reset = 1'b0;
    t_ref = 0;
    check_all("after_midreset");

    do_adj(3, 1'b1);
    do_adj(47, 1'b0);
    push(5, 0, "scan");
    check_all("scan_frame");

    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 5);
      k  = $urandom_range(1, 12);
      case (op)
        0: do_ticks(k, 1'b0);
        1: do_ticks(k, 1'b1);
        2: do_adj(k, 1'b0);
        3: do_adj(k, 1'b1);
        4: do_clr();
        default: begin
          do_clr();
          do_adj($urandom_range(1, 3), 1'b0);
          do_ticks(k, 1'b1);
        end
      endcase
      check_all($sformatf("rand%0d_op%0d", it, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
`default_nettype wire

// File: doc/mmss_timer.md
MMSS_TIMER -- requirements
Module: mmss_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 1, count rate in run mode.
REQ-003 SHALL have parameter ADJ_HZ, default 2, increment rate in adjust mode.
REQ-004 SHALL have parameter BLINK_HZ, default 2, blink toggle rate.
REQ-005 SHALL have parameter SCAN_HZ, default 1000, digit-advance rate.
REQ-006 SHALL have parameter MAX_MIN, default 99, highest minutes value; legal range 1..99.
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-009 SHALL have port run, input, 1, level; 1 = count, 0 = hold.
REQ-010 SHALL have port adjust, input, 1, level; 1 = adjust mode.
REQ-011 SHALL have port sel, input, 1, level; adjust field, 0 = seconds, 1 = minutes.
REQ-012 SHALL have port dir, input, 1, level; 0 = count up, 1 = count down.
REQ-013 SHALL have port clr, input, 1, one-cycle pulse; synchronous clear to 00:00.
REQ-014 SHALL have port seg, output, 8, active-low segments, bit 7 = dp, bits 6:0 = g..a.
REQ-015 SHALL have port an, output, 4, active-low anodes, an[0] = seconds units.
REQ-016 SHALL have port expired, output, 1, one-cycle pulse when a down-count reaches 00:00.
REQ-017 SHALL have port at_zero, output, 1, level; 1 while the time equals 00:00.

Function
REQ-018 SHALL derive all rates as single-cycle strobes from free-running prescalers on clk; no derived clocks.
REQ-019 SHALL hold time as four BCD digits: s0 (0-9), s1 (0-5), m0 (0-9), m1 (0-9), minutes bounded by MAX_MIN.
REQ-020 SHALL run the tick prescaler only while run=1 and adjust=0; SHALL clear it on clr.
REQ-021 SHALL, on a tick with dir=0: increment time; seconds 59->00 carrying into minutes; MAX_MIN:59 -> 00:00.
REQ-022 SHALL, on a tick with dir=1: decrement time; seconds 00->59 borrowing from minutes; at 00:00 hold, no wrap.
REQ-023 SHALL assert expired for exactly one cycle on the tick that moves time from 00:01 to 00:00 with dir=1; never on a clr or reset.
REQ-024 SHALL, in adjust mode on each ADJ_HZ strobe, increment only the selected field: seconds 59->00 without carry; minutes MAX_MIN->00.
REQ-025 SHALL ignore run and dir while adjust=1.
REQ-026 SHALL give clr priority over a simultaneous tick or adjust strobe.
REQ-027 SHALL advance a 2-bit scan index 0->1->2->3->0 on each scan strobe.
REQ-028 SHALL register an and seg in the same cycle from the same scan index, so they never refer to different digits.
REQ-029 SHALL drive an one-hot-low for the scanned digit: index 0 -> 4'b1110 ... index 3 -> 4'b0111.
REQ-030 SHALL, with adjust=1 and blink phase 1, drive an=4'b1111 on scan slots of the selected field (sel=0: idx 0,1; sel=1: idx 2,3).
REQ-031 SHALL drive dp low (lit) on index 2 only, as the minutes/seconds separator.
REQ-032 SHALL encode digit values 0-9 to standard active-low patterns (0 -> 7'b1000000); values 10-15 SHALL encode to all segments off.
REQ-033 SHALL make at_zero combinational from the digit registers.

Reset
REQ-034 SHALL, on reset, asynchronously set digits to 0, prescalers to 0, scan index to 0, blink phase to 0, an=4'b1111, seg=8'hFF, expired=0.
REQ-035 SHALL resume from 00:00 on the first clk edge after reset deasserts, with no spurious expired pulse.

Structure
REQ-036 SHALL place the seven-segment encoding table, blank and dp constants, and the sel encodings in shared package timer_pkg.
REQ-037 SHALL use one sub-module, strobe_gen (parameter DIV, inputs clk/reset/en/clr, output one-cycle strobe), instantiated once per rate.
REQ-038 SHALL compute each divisor as CLK_HZ/rate at elaboration time and size its counter with $clog2.

Verification (CLK_HZ=1000, TICK_HZ=100, ADJ_HZ=50, BLINK_HZ=25, SCAN_HZ=500)
REQ-039 SHALL cover up-count from 00:00 for 60 ticks -> 01:00; preload 99:59, 1 tick -> 00:00.
REQ-040 SHALL cover load 00:02 (adjust), dir=1, run -> 00:01, then 00:00 with expired high one cycle; 5 more ticks -> holds 00:00, expired stays 0.
REQ-041 SHALL cover adjust=1, sel=0 from 00:58, 3 strobes -> 00:01 with minutes unchanged; seconds slots (an=1110/1101) blanked in alternate blink phases.
REQ-042 SHALL cover clr in the same cycle as a tick at 12:34 -> 00:00 next cycle; next tick no earlier than a full divisor later.
REQ-043 SHALL cover reset asserted mid-count at 07:15 -> immediate an=4'b1111, seg=8'hFF, digits 0, expired=0.
REQ-044 SHALL cover 8 scan strobes -> an sequence 1110,1101,1011,0111 twice, seg matching each digit, dp low only with an=1011.
